router_port_demux: RTL and testbench

// - Registered, frame-aware 1-to-NUM_PORTS demux for one router input port.
// - Decodes the serial destination address at frame start, skips the pad phase, then steers data to one output.
// - Replaces the combinational per-bit 1x16 decoder; sits between a router input pin group and the crossbar/arbiter.
// - Unselected outputs are driven to idle values, never X.

---
 rtl/router_port_demux.sv | 152 +++++++++++++++
 tb/tb_router_port_demux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_demux.sv
// rtl/router_port_demux.sv - registered frame-aware 1-to-NUM_PORTS demux for one router input port.
// Optional saturating error counter output err_cnt when ROUTER_DEMUX_ERRCNT_EN is defined.
module router_port_demux #(
    parameter int NUM_PORTS  = 16,
    parameter int ADDR_W     = $clog2(NUM_PORTS),
    parameter int PAD_CYCLES = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_n,
    input  logic                 valid_n,
    input  logic                 din,
    output logic [NUM_PORTS-1:0] frameo_n,
    output logic [NUM_PORTS-1:0] valido_n,
    output logic [NUM_PORTS-1:0] dout,
    output logic                 busy,
    output logic [ADDR_W-1:0]    addr_o,
    output logic                 proto_err
`ifdef ROUTER_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    localparam int BCW = $clog2(ADDR_W + 1);
    localparam int PCW = $clog2(PAD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_PAD  = 2'd2,
        S_DATA = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PCW-1:0]         pad_cnt_q, pad_cnt_d;
    logic [NUM_PORTS-1:0]   frameo_q, frameo_d;
    logic [NUM_PORTS-1:0]   valido_q, valido_d;
    logic [NUM_PORTS-1:0]   dout_q, dout_d;
    logic                   err_q, viol;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            bit_cnt_q <= '0;
            pad_cnt_q <= '0;
            frameo_q  <= '1;
            valido_q  <= '1;
            dout_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bit_cnt_q <= bit_cnt_d;
            pad_cnt_q <= pad_cnt_d;
            frameo_q  <= frameo_d;
            valido_q  <= valido_d;
            dout_q    <= dout_d;
            err_q     <= viol;
        end
    end

    // Outputs default to idle every cycle; only DATA drives the selected channel,
    // so the selected output returns to idle on the edge after the frame ends.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bit_cnt_d = bit_cnt_q;
        pad_cnt_d = pad_cnt_q;
        frameo_d  = '1;
        valido_d  = '1;
        dout_d    = '0;
        viol      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!frame_n) begin
                    addr_d[0] = din;
                    bit_cnt_d = BCW'(1);
                    pad_cnt_d = '0;
                    state_d   = (ADDR_W == 1) ? S_PAD : S_ADDR;
                end
            end
            S_ADDR: begin
                if (frame_n) begin
                    viol = 1'b1;
                end else begin
                    for (int i = 0; i < ADDR_W; i++) begin
                        if (bit_cnt_q == BCW'(i)) addr_d[i] = din;
                    end
                    if (bit_cnt_q == BCW'(ADDR_W - 1)) begin
                        pad_cnt_d = '0;
                        state_d   = S_PAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            S_PAD: begin
                if (frame_n || !valid_n) begin
                    viol = 1'b1;
                end else if (pad_cnt_q == PCW'(PAD_CYCLES - 1)) begin
                    pad_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    pad_cnt_d = pad_cnt_q + PCW'(1);
                end
            end
            S_DATA: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (addr_q == ADDR_W'(i)) begin
                        frameo_d[i] = frame_n;
                        valido_d[i] = valid_n;
                        dout_d[i]   = din;
                    end
                end
                if (frame_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // An aborted frame never reached DATA, so outputs are already idle.
        if (viol) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            pad_cnt_d = '0;
        end
    end

    assign frameo_n  = frameo_q;
    assign valido_n  = valido_q;
    assign dout      = dout_q;
    assign busy      = (state_q != S_IDLE);
    assign addr_o    = addr_q;
    assign proto_err = err_q;

`ifdef ROUTER_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= 8'h00;
        end else if (viol && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_port_demux.sv
// tb/tb_router_port_demux.sv - frame scoreboard bench for router_port_demux (16-port and 4-port instances).
module tb_router_port_demux;

    localparam int NP = 16;
    localparam int AW = 4;
    localparam int PC = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic frame_n = 1'b1, valid_n = 1'b1, din = 1'b0;
    logic [NP-1:0] frameo_n, valido_n, dout;
    logic busy, proto_err;
    logic [AW-1:0] addr_o;

    logic f4 = 1'b1, v4 = 1'b1, d4 = 1'b0;
    logic [3:0] fo4, vo4, do4;
    logic busy4, err4;
    logic [1:0] addr4;

`ifdef ROUTER_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt, err_cnt4;
`endif

    router_port_demux #(.NUM_PORTS(NP), .PAD_CYCLES(PC)) dut (
        .clock(clock), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
        .frameo_n(frameo_n), .valido_n(valido_n), .dout(dout), .busy(busy),
        .addr_o(addr_o), .proto_err(proto_err)
`ifdef ROUTER_DEMUX_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    router_port_demux #(.NUM_PORTS(4), .PAD_CYCLES(PC)) dut4 (
        .clock(clock), .reset_n(reset_n), .frame_n(f4), .valid_n(v4), .din(d4),
        .frameo_n(fo4), .valido_n(vo4), .dout(do4), .busy(busy4),
        .addr_o(addr4), .proto_err(err4)
`ifdef ROUTER_DEMUX_ERRCNT_EN
        , .err_cnt(err_cnt4)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic [NP-1:0] exp_frameo = '1, exp_valido = '1, exp_dout = '0;
    logic exp_busy = 1'b0, exp_err = 1'b0;
    logic [AW-1:0] model_addr = '0, exp_addr = '0;
    int model_errcnt = 0;
    logic [7:0] cap_byte;
    int cap_vcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("frameo_n", 32'(frameo_n), 32'(exp_frameo));
            chk("valido_n", 32'(valido_n), 32'(exp_valido));
            chk("dout", 32'(dout), 32'(exp_dout));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("addr_o", 32'(addr_o), 32'(exp_addr));
            chk("proto_err", 32'(proto_err), 32'(exp_err));
`ifdef ROUTER_DEMUX_ERRCNT_EN
            chk("err_cnt", 32'(err_cnt), 32'(model_errcnt));
`endif
        end
    end

    // One edge of stimulus plus what the scoreboard requires after that edge.
    task automatic tick(input logic f, input logic v, input logic d, input int oport,
                        input logic ef, input logic ev, input logic ed,
                        input logic eb, input logic ee);
        frame_n = f; valid_n = v; din = d;
        @(posedge clock); #1;
        exp_frameo = '1; exp_valido = '1; exp_dout = '0;
        if (oport >= 0) begin
            exp_frameo[oport] = ef;
            exp_valido[oport] = ev;
            exp_dout[oport]   = ed;
        end
        exp_busy = eb;
        exp_err  = ee;
        if (ee && model_errcnt < 255) model_errcnt++;
        exp_addr = model_addr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_addr_pad(input logic [AW-1:0] a, input int npad);
        for (int i = 0; i < AW; i++) begin
            model_addr[i] = a[i];
            tick(1'b0, 1'b1, a[i], -1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        for (int p = 0; p < npad; p++)
            tick(1'b0, 1'b1, p[0], -1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [AW-1:0] a, input logic [7:0] data,
                              input logic [7:0] vmask_n, input int stop_after);
        logic last;
        send_addr_pad(a, PC);
        cap_byte = 8'h00;
        cap_vcnt = 0;
        for (int j = 0; j < 8; j++) begin
            if (j == stop_after) return;
            last = (j == 7);
            tick(last, vmask_n[j], data[j], int'(a), last, vmask_n[j], data[j], !last, 1'b0);
            cap_byte = {dout[a], cap_byte[7:1]};
            if (!valido_n[a]) cap_vcnt++;
        end
    endtask

    task automatic viol_addr(input logic b);
        model_addr[0] = b;
        tick(1'b0, 1'b1, b, -1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] first_cap;
        logic [3:0] d4seq;
        logic last;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_frameo", 32'(frameo_n), 32'hFFFF);
        chk("rst_valido", 32'(valido_n), 32'hFFFF);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_addr", 32'(addr_o), 32'h0);
        chk("rst_err", 32'(proto_err), 32'h0);
`ifdef ROUTER_DEMUX_ERRCNT_EN
        chk("rst_errcnt", 32'(err_cnt), 32'h0);
`endif
        reset_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        send_frame(4'd3, 8'hA5, 8'h00, 8);
        chk("a5_payload", 32'(cap_byte), 32'hA5);
        chk("a5_valid_cycles", 32'(cap_vcnt), 32'd8);
        chk("a5_addr", 32'(addr_o), 32'd3);
        chk("a5_frameo_rise", 32'(frameo_n[3]), 32'd1);
        chk("a5_busy_low", 32'(busy), 32'd0);
        idle(2);

        send_frame(4'd15, 8'h3C, 8'h00, 8);
        first_cap = cap_byte;
        send_frame(4'd0, 8'hC3, 8'h00, 8);
        chk("b2b_first", 32'(first_cap), 32'h3C);
        chk("b2b_second", 32'(cap_byte), 32'hC3);
        idle(2);

        send_frame(4'd9, 8'h5A, 8'b0001_0100, 8);
        chk("bubble_valid_cycles", 32'(cap_vcnt), 32'd6);
        idle(1);

        send_addr_pad(4'd6, 1);
        tick(1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pad_frame_err", 32'(proto_err), 32'd1);
`ifdef ROUTER_DEMUX_ERRCNT_EN
        chk("pad_frame_errcnt", 32'(err_cnt), 32'd1);
`endif
        idle(1);
        chk("pad_frame_err_clr", 32'(proto_err), 32'd0);

        send_addr_pad(4'd12, 2);
        tick(1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pad_valid_err", 32'(proto_err), 32'd1);
        chk("pad_valid_outs", 32'(valido_n), 32'hFFFF);
        idle(2);

        send_frame(4'd7, 8'hFF, 8'h00, 3);
        chk_en = 1'b0;
        chk("pre_rst_frameo7", 32'(frameo_n[7]), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("async_frameo7", 32'(frameo_n[7]), 32'd1);
        chk("async_valido7", 32'(valido_n[7]), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        frame_n = 1'b1; valid_n = 1'b1; din = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_addr = '0; exp_addr = '0; model_errcnt = 0;
        exp_frameo = '1; exp_valido = '1; exp_dout = '0; exp_busy = 1'b0; exp_err = 1'b0;
        chk_en = 1'b1;
        idle(1);
        send_frame(4'd7, 8'h81, 8'h00, 8);
        chk("post_rst_payload", 32'(cap_byte), 32'h81);
        idle(1);

        for (int n = 0; n < 300; n++) viol_addr(n[1]);
`ifdef ROUTER_DEMUX_ERRCNT_EN
        chk("errcnt_sat", 32'(err_cnt), 32'hFF);
`endif
        idle(2);

        // 4-port instance: addr 2'd2 (din 0,1), five pad cycles, data 1,1,0,1.
        d4seq = 4'b1011;
        for (int i = 0; i < 2; i++) begin
            f4 = 1'b0; v4 = 1'b1; d4 = (i == 1);
            idle(1);
        end
        for (int p = 0; p < PC; p++) begin
            f4 = 1'b0; v4 = 1'b1; d4 = 1'b0;
            idle(1);
        end
        for (int j = 0; j < 4; j++) begin
            last = (j == 3);
            f4 = last; v4 = 1'b0; d4 = d4seq[j];
            idle(1);
            chk("p4_dout", 32'(do4), d4seq[j] ? 32'h4 : 32'h0);
            chk("p4_valido", 32'(vo4), 32'hB);
            chk("p4_frameo", 32'(fo4), last ? 32'hF : 32'hB);
            chk("p4_busy", 32'(busy4), last ? 32'h0 : 32'h1);
            chk("p4_addr", 32'(addr4), 32'h2);
        end
        f4 = 1'b1; v4 = 1'b1; d4 = 1'b0;
        idle(1);
        chk("p4_idle_frameo", 32'(fo4), 32'hF);
        chk("p4_idle_valido", 32'(vo4), 32'hF);
        chk("p4_idle_dout", 32'(do4), 32'h0);
        chk("p4_no_err", 32'(err4), 32'h0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
